axis_ram_writer: RTL and testbench
==================================

// Module: axis_ram_writer
// PURPOSE
//  Stream-to-memory writer at the producer end of the quad-buffer sync manager handshake.
//  Accepts AXI-Stream samples, writes each one to DDR at the address the sync manager provides
//  (SM_write_buffer), and reports progress back to the manager:
//   SM_reading = sample accepted; SM_writing = write response received.
//  Sits between the signal-processing stream chain and the HP AXI4 port.
// PARAMETERS
//  MM_ADDR_WIDTH  32  AXI4 address width; width of SM_write_buffer
//  DATA_WIDTH     32  stream/AXI data width in bits; power of two, 32 or 64
// PORTS
//  aclk           in   1                system clock
//  aresetn        in   1                reset; sync, active-low
//  enable         in   1                1 = accept new samples; 0 = finish current write, then hold
//  s_axis_tdata   in   DATA_WIDTH       input sample
//  s_axis_tvalid  in   1                sample valid
//  s_axis_tready  out  1                sample accepted when tvalid&tready
//  m_axi_awaddr   out  MM_ADDR_WIDTH    write address
//  m_axi_awlen    out  8                const 0 (single beat)
//  m_axi_awsize   out  3                const log2(DATA_WIDTH/8)
//  m_axi_awburst  out  2                const 2'b01 INCR
//  m_axi_awcache  out  4                const 4'b0011
//  m_axi_awprot   out  3                const 3'b000
//  m_axi_awvalid  out  1                address valid
//  m_axi_awready  in   1                address accepted
//  m_axi_wdata    out  DATA_WIDTH       write data
//  m_axi_wstrb    out  DATA_WIDTH/8     const all ones
//  m_axi_wlast    out  1                const 1
//  m_axi_wvalid   out  1                data valid
//  m_axi_wready   in   1                data accepted
//  m_axi_bresp    in   2                write response
//  m_axi_bvalid   in   1                response valid
//  m_axi_bready   out  1                response accept
//  SM_write_buffer in  MM_ADDR_WIDTH    next write address from sync manager
//  SM_reading     out  1                1-cycle pulse per accepted sample
//  SM_writing     out  1                1-cycle pulse per completed write (B handshake)
//  error          out  1                sticky: set on any bresp != OKAY
// BEHAVIOUR
//  - Reset: state IDLE; tready, awvalid, wvalid, bready, SM_reading, SM_writing, error = 0;
//    awaddr and wdata = 0.
//  - FSM IDLE -> WRITE -> RESP -> IDLE. At most one transaction outstanding.
//  - IDLE: tready = enable (registered).
//    On tvalid&tready:
//     - latch tdata -> wdata and SM_write_buffer -> awaddr;
//     - pulse SM_reading in the same cycle;
//     - next cycle go to WRITE with awvalid = wvalid = 1.
//  - WRITE: awvalid and wvalid drop independently on their own handshake; AXI allows AW and W
//    in either order or together. Once both are done, go to RESP with bready = 1.
//    awaddr/wdata stay stable while valid.
//  - RESP: on bvalid&bready:
//     - pulse SM_writing;
//     - set error if bresp != 2'b00;
//     - bready = 0; go to IDLE.
//    tready is re-raised at the earliest one cycle after returning to IDLE.
//  - Minimum sample period 4 cycles. SM_write_buffer is always sampled at least 2 cycles after
//    the previous SM_reading, so the manager's registered address is settled.
//  - The address is taken as-is: no alignment or width arithmetic in this block.
//  - enable low during WRITE/RESP: the transaction completes normally; no new acceptance.
//  - Back-pressure: awready/wready/bvalid may stall indefinitely; no timeout.
//    Outputs hold until handshake.
//  - SM_reading and SM_writing are never high in the same cycle (IDLE vs RESP).
//  - Reset mid-transaction: all valids drop immediately. The in-flight write is abandoned;
//    the interconnect must also be reset. error clears only on reset.
// STRUCTURE
//  - Shared package: state encodings (IDLE/WRITE/RESP) and AXI constants
//    (BURST_INCR = 2'b01, RESP_OKAY = 2'b00, CACHE_BUFFERABLE = 4'b0011).
//  - Single module, no sub-module. Two-process style: state registers + always @* next-state.
// TESTING
//  1. Reset then idle, tvalid=0: all valids 0, tready=1 (enable=1), no SM pulses for 100 cycles.
//  2. One sample 0xDEADBEEF with SM_write_buffer=0x1E000000, awready=wready=bvalid=1:
//     AW addr 0x1E000000, W data 0xDEADBEEF, wstrb 0xF; SM_reading then SM_writing once each.
//  3. wready held 0 for 10 cycles, awready=1: AW done first, wvalid held with stable data;
//     B accepted only after W; exactly one SM_writing.
//  4. Stream of 16 back-to-back samples, SM_write_buffer stepped +4 after each SM_reading:
//     16 writes at ascending addresses; 16 SM_reading and 16 SM_writing pulses;
//     never 2 outstanding.
//  5. bresp=2'b10 on 3rd of 5 writes: error rises after 3rd B and stays 1;
//     all 5 SM_writing pulses still issued.
//  6. aresetn low while in RESP with bvalid=0: next cycle all outputs at reset values;
//     after release, a new sample writes normally.

Source files
------------

// File: rtl/axis_ram_writer_pkg.sv
// Shared definitions for the stream-to-DDR writer: FSM state encoding and
// the fixed AXI4 attribute values driven on the write channels.
package axis_ram_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } wr_state_t;

    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [3:0] CACHE_BUFFERABLE = 4'b0011;
    localparam logic [2:0] PROT_NONE        = 3'b000;
    localparam logic [7:0] LEN_SINGLE       = 8'd0;

    // AXI size code (log2 of bytes per beat) for a power-of-two byte count.
    function automatic logic [2:0] axsize_of(input int bytes);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                code = 3'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/axis_ram_writer.sv
// Stream-to-memory writer. Each accepted AXI-Stream sample becomes one
// single-beat AXI4 write at the address supplied by the sync manager.
// Only one write is ever outstanding; progress is reported back to the
// manager as SM_reading (sample taken) and SM_writing (B response seen).
module axis_ram_writer
    import axis_ram_writer_pkg::*;
#(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [MM_ADDR_WIDTH-1:0]  m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [MM_ADDR_WIDTH-1:0]  SM_write_buffer,
    output logic                      SM_reading,
    output logic                      SM_writing,
    output logic                      error
);

    localparam logic [2:0] AWSIZE = axsize_of(DATA_WIDTH / 8);

    wr_state_t                  state_reg,   state_next;
    logic                       tready_reg,  tready_next;
    logic                       awvalid_reg, awvalid_next;
    logic                       wvalid_reg,  wvalid_next;
    logic                       bready_reg,  bready_next;
    logic                       error_reg,   error_next;
    logic [MM_ADDR_WIDTH-1:0]   awaddr_reg,  awaddr_next;
    logic [DATA_WIDTH-1:0]      wdata_reg,   wdata_next;

    logic sample_hs;
    logic aw_done;
    logic w_done;
    logic b_hs;

    // A channel counts as done once its handshake has happened, either in an
    // earlier cycle (valid already dropped) or on the current edge.
    assign sample_hs = s_axis_tvalid & tready_reg;
    assign aw_done   = ~awvalid_reg | m_axi_awready;
    assign w_done    = ~wvalid_reg  | m_axi_wready;
    assign b_hs      = m_axi_bvalid & bready_reg;

    // Next-state and next-output logic for the IDLE -> WRITE -> RESP loop.
    always_comb begin
        state_next   = state_reg;
        tready_next  = tready_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        bready_next  = bready_reg;
        error_next   = error_reg;
        awaddr_next  = awaddr_reg;
        wdata_next   = wdata_reg;

        case (state_reg)
            ST_IDLE: begin
                // tready follows enable one cycle late, so after a return
                // from RESP it cannot rise before the following cycle.
                tready_next = enable;
                if (sample_hs) begin
                    awaddr_next  = SM_write_buffer;
                    wdata_next   = s_axis_tdata;
                    tready_next  = 1'b0;
                    awvalid_next = 1'b1;
                    wvalid_next  = 1'b1;
                    state_next   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                tready_next = 1'b0;
                if (awvalid_reg && m_axi_awready) begin
                    awvalid_next = 1'b0;
                end
                if (wvalid_reg && m_axi_wready) begin
                    wvalid_next = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_next = 1'b1;
                    state_next  = ST_RESP;
                end
            end
            ST_RESP: begin
                tready_next = 1'b0;
                if (b_hs) begin
                    bready_next = 1'b0;
                    if (m_axi_bresp != RESP_OKAY) begin
                        error_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            end
            default: begin
                tready_next  = 1'b0;
                awvalid_next = 1'b0;
                wvalid_next  = 1'b0;
                bready_next  = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight write.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg   <= ST_IDLE;
            tready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            error_reg   <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            tready_reg  <= tready_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            bready_reg  <= bready_next;
            error_reg   <= error_next;
            awaddr_reg  <= awaddr_next;
            wdata_reg   <= wdata_next;
        end
    end

    assign s_axis_tready = tready_reg;
    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_awlen   = LEN_SINGLE;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awcache = CACHE_BUFFERABLE;
    assign m_axi_awprot  = PROT_NONE;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign error         = error_reg;

    // Progress pulses mark the handshake cycles themselves. tready is only
    // ever high in IDLE and bready only in RESP, so they cannot coincide.
    assign SM_reading = sample_hs;
    assign SM_writing = b_hs;

endmodule

// File: tb/tb_axis_ram_writer.sv
// Directed bench for axis_ram_writer: reset, idle, single write, W stall,
// back-to-back stream, error response and reset during RESP.
module tb_axis_ram_writer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] SM_write_buffer;
    logic        SM_reading;
    logic        SM_writing;
    logic        error;

    axis_ram_writer #(.MM_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .SM_write_buffer(SM_write_buffer), .SM_reading(SM_reading), .SM_writing(SM_writing),
        .error(error)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Bus monitor state, sampled on the falling edge.
    int          cyc = 0;
    int          n_read = 0;
    int          n_write = 0;
    int          outstanding = 0;
    int          over_cnt = 0;
    int          overlap_cnt = 0;
    int          b_with_w_cnt = 0;
    int          last_read_cyc = 0;
    int          last_write_cyc = 0;
    logic [31:0] aw_addr_q[$];
    logic [31:0] w_data_q[$];
    logic [3:0]  w_strb_last = 4'h0;

    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            outstanding = 0;
        end else begin
            if (SM_reading) begin
                n_read++;
                outstanding++;
                last_read_cyc = cyc;
            end
            if (SM_writing) begin
                n_write++;
                outstanding--;
                last_write_cyc = cyc;
                $display("txn %0d: awaddr=%08h wdata=%08h bresp=%0d", n_write,
                         m_axi_awaddr, m_axi_wdata, m_axi_bresp);
            end
            if (SM_reading && SM_writing) overlap_cnt++;
            if (outstanding > 1) over_cnt++;
            if (m_axi_awvalid && m_axi_awready) aw_addr_q.push_back(m_axi_awaddr);
            if (m_axi_wvalid && m_axi_wready) begin
                w_data_q.push_back(m_axi_wdata);
                w_strb_last = m_axi_wstrb;
            end
            if (m_axi_bready && m_axi_wvalid) b_with_w_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_sample(input logic [31:0] data, input logic [31:0] addr, output bit got);
        s_axis_tdata    = data;
        SM_write_buffer = addr;
        s_axis_tvalid   = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (s_axis_tready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_writes(input int target, output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n_write >= target) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; enable = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        SM_write_buffer = '0;
        repeat (3) tick();
        n_checks++; if ({s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 4'b0000)
            $display("FAIL rst_valids: got %b want 0000", {s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}); else n_pass++;
        n_checks++; if ({SM_reading, SM_writing, error} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {SM_reading, SM_writing, error}); else n_pass++;
        n_checks++; if ({m_axi_awaddr, m_axi_wdata} !== 64'h0)
            $display("FAIL rst_addr_data: got %h want 0", {m_axi_awaddr, m_axi_wdata}); else n_pass++;
        n_checks++; if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_wstrb, m_axi_wlast}
                        !== {8'd0, 3'd2, 2'b01, 4'b0011, 3'b000, 4'hF, 1'b1})
            $display("FAIL const_attrs: got len=%0d size=%0d burst=%0d cache=%0d prot=%0d strb=%h last=%0d",
                     m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_wstrb, m_axi_wlast);
        else n_pass++;
        aresetn = 1'b1;
    endtask

    task automatic test_idle();
        int bad = 0;
        int r0 = n_read;
        int w0 = n_write;
        repeat (100) begin
            tick();
            if (m_axi_awvalid || m_axi_wvalid || m_axi_bready || SM_reading || SM_writing) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL idle_quiet: got %0d active cycles want 0", bad); else n_pass++;
        n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL idle_tready: got %b want 1", s_axis_tready); else n_pass++;
        n_checks++; if ((n_read - r0) + (n_write - w0) !== 0)
            $display("FAIL idle_pulses: got %0d want 0", (n_read - r0) + (n_write - w0)); else n_pass++;
    endtask

    task automatic test_single();
        bit got;
        int r0 = n_read;
        int w0 = n_write;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        send_sample(32'hDEADBEEF, 32'h1E000000, got);
        n_checks++; if (got !== 1'b1) $display("FAIL single_accept: got %b want 1", got); else n_pass++;
        wait_writes(w0 + 1, got);
        n_checks++; if (got !== 1'b1) $display("FAIL single_timeout: got %b want 1", got); else n_pass++;
        repeat (3) tick();
        n_checks++; if (aw_addr_q[$] !== 32'h1E000000) $display("FAIL single_awaddr: got %h want 1e000000", aw_addr_q[$]); else n_pass++;
        n_checks++; if (w_data_q[$] !== 32'hDEADBEEF) $display("FAIL single_wdata: got %h want deadbeef", w_data_q[$]); else n_pass++;
        n_checks++; if (w_strb_last !== 4'hF) $display("FAIL single_wstrb: got %h want f", w_strb_last); else n_pass++;
        n_checks++; if ({n_read - r0, n_write - w0} !== {32'd1, 32'd1})
            $display("FAIL single_pulses: got rd=%0d wr=%0d want 1/1", n_read - r0, n_write - w0); else n_pass++;
        n_checks++; if (last_write_cyc - last_read_cyc !== 2)
            $display("FAIL single_latency: got %0d want 2", last_write_cyc - last_read_cyc); else n_pass++;
    endtask

    task automatic test_w_stall();
        bit got;
        int bad = 0;
        int w0 = n_write;
        int b0 = b_with_w_cnt;
        m_axi_awready = 1'b1; m_axi_wready = 1'b0; m_axi_bvalid = 1'b1;
        send_sample(32'hA5A55A5A, 32'h1E000100, got);
        n_checks++; if (got !== 1'b1) $display("FAIL stall_accept: got %b want 1", got); else n_pass++;
        repeat (10) begin
            if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== 32'hA5A55A5A) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) $display("FAIL stall_w_hold: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b010)
            $display("FAIL stall_state: got aw/w/b=%b want 010", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); else n_pass++;
        n_checks++; if (n_write !== w0) $display("FAIL stall_no_b: got %0d want %0d", n_write, w0); else n_pass++;
        n_checks++; if (aw_addr_q[$] !== 32'h1E000100) $display("FAIL stall_awaddr: got %h want 1e000100", aw_addr_q[$]); else n_pass++;
        m_axi_wready = 1'b1;
        wait_writes(w0 + 1, got);
        repeat (5) tick();
        n_checks++; if (n_write - w0 !== 1) $display("FAIL stall_one_b: got %0d want 1", n_write - w0); else n_pass++;
        n_checks++; if (w_data_q[$] !== 32'hA5A55A5A) $display("FAIL stall_wdata: got %h want a5a55a5a", w_data_q[$]); else n_pass++;
        n_checks++; if (b_with_w_cnt !== b0) $display("FAIL stall_b_before_w: got %0d want %0d", b_with_w_cnt, b0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got;
        int misses = 0;
        int bad_addr = 0;
        int bad_data = 0;
        int r0 = n_read;
        int w0 = n_write;
        int q0 = aw_addr_q.size();
        int d0 = w_data_q.size();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata    = 32'h10000000 + i;
            SM_write_buffer = 32'h1E001000 + 4 * i;
            got = 1'b0;
            for (int j = 0; j < 50; j++) begin
                if (s_axis_tready) begin
                    got = 1'b1;
                    break;
                end
                tick();
            end
            if (!got) misses++;
            tick();
        end
        s_axis_tvalid = 1'b0;
        wait_writes(w0 + 16, got);
        repeat (3) tick();
        n_checks++; if (misses !== 0) $display("FAIL b2b_accept: got %0d misses want 0", misses); else n_pass++;
        n_checks++; if ({n_read - r0, n_write - w0} !== {32'd16, 32'd16})
            $display("FAIL b2b_pulses: got rd=%0d wr=%0d want 16/16", n_read - r0, n_write - w0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            if (q0 + i >= aw_addr_q.size() || aw_addr_q[q0 + i] !== 32'h1E001000 + 4 * i) bad_addr++;
            if (d0 + i >= w_data_q.size() || w_data_q[d0 + i] !== 32'h10000000 + i) bad_data++;
        end
        n_checks++; if (bad_addr !== 0) $display("FAIL b2b_addr: got %0d wrong want 0", bad_addr); else n_pass++;
        n_checks++; if (bad_data !== 0) $display("FAIL b2b_data: got %0d wrong want 0", bad_data); else n_pass++;
        n_checks++; if (over_cnt !== 0) $display("FAIL b2b_outstanding: got %0d cycles >1 want 0", over_cnt); else n_pass++;
        n_checks++; if (overlap_cnt !== 0) $display("FAIL sm_overlap: got %0d want 0", overlap_cnt); else n_pass++;
    endtask

    task automatic test_error();
        bit got;
        int w0 = n_write;
        for (int i = 0; i < 5; i++) begin
            m_axi_bresp = (i == 2) ? 2'b10 : 2'b00;
            send_sample(32'hE0000000 + i, 32'h1E002000 + 4 * i, got);
            wait_writes(w0 + i + 1, got);
            tick();
            n_checks++; if (error !== (i >= 2 ? 1'b1 : 1'b0))
                $display("FAIL err_after_%0d: got %b want %b", i, error, (i >= 2 ? 1'b1 : 1'b0)); else n_pass++;
        end
        m_axi_bresp = 2'b00;
        n_checks++; if (n_write - w0 !== 5) $display("FAIL err_pulses: got %0d want 5", n_write - w0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit got;
        int w0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
        send_sample(32'h12345678, 32'h1E000200, got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_axi_bready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        repeat (3) tick();
        n_checks++; if ({got, m_axi_bready} !== 2'b11) $display("FAIL mid_in_resp: got %b want 11", {got, m_axi_bready}); else n_pass++;
        aresetn = 1'b0;
        tick();
        n_checks++; if ({s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, SM_reading, SM_writing, error} !== 7'b0)
            $display("FAIL mid_rst_ctrl: got %b want 0000000",
                     {s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, SM_reading, SM_writing, error}); else n_pass++;
        n_checks++; if ({m_axi_awaddr, m_axi_wdata} !== 64'h0)
            $display("FAIL mid_rst_regs: got %h want 0", {m_axi_awaddr, m_axi_wdata}); else n_pass++;
        aresetn = 1'b1;
        m_axi_bvalid = 1'b1;
        w0 = n_write;
        send_sample(32'hCAFEF00D, 32'h1E000300, got);
        wait_writes(w0 + 1, got);
        repeat (2) tick();
        n_checks++; if ({got, aw_addr_q[$], w_data_q[$]} !== {1'b1, 32'h1E000300, 32'hCAFEF00D})
            $display("FAIL mid_recover: got ok=%b addr=%h data=%h want 1/1e000300/cafef00d", got, aw_addr_q[$], w_data_q[$]); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL mid_error_clear: got %b want 0", error); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_w_stall();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
